multicycle_control: RTL and testbench
=====================================

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameters SHALL be:
- TIMEOUT, 16: maximum memory-wait cycles before abort.
- CNT_W, 32: width of the retired-instruction counter.
- ALU_OP_W, 3: width of alu_op.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  opcode field of the instruction register.
- imem_ready  in  1  instruction memory handshake done.
- dmem_ready  in  1  data memory handshake done.
- imem_req  out  1  instruction fetch request.
- ir_write  out  1  latch instruction register.
- pc_write  out  1  update PC.
- alu_src  out  1  ALU B operand is immediate.
- branch  out  1  branch compare/resolve cycle.
- mem_read  out  1  data load request.
- mem_write  out  1  data store request.
- reg_write  out  1  register file write strobe.
- mem_to_reg  out  2  writeback source: 00 ALU, 01 memory, 10 PC+4.
- alu_op  out  ALU_OP_W  ALU operation class.
- timeout_err  out  1  one-cycle pulse on memory abort.
- trap  out  1  illegal-opcode trap (configuration dependent).
- instr_cnt  out  CNT_W  retired-instruction count.

Function
REQ-003 The FSM SHALL have the states FETCH, DECODE, EXEC, MEM, WB and TRAP; all outputs SHALL be Moore outputs decoded from the state and the opcode latched in DECODE.
REQ-004 In FETCH, imem_req SHALL be 1; when imem_ready is 1, ir_write and pc_write SHALL be 1 for that cycle and the next state SHALL be DECODE.
REQ-005 In DECODE, the opcode SHALL be latched; legal opcodes SHALL go to EXEC; illegal opcodes SHALL follow REQ-016.
REQ-006 The legal opcodes and their alu_op values SHALL be:
- R 0110011 -> alu_op 010.
- I-ALU 0010011 -> alu_op 011.
- LOAD 0000011 and STORE 0100011 -> alu_op 000, alu_src 1.
- BRANCH 1100011 -> alu_op 001.
- JAL 1101111 and JALR 1100111 -> alu_op 000.
- LUI 0110111 -> alu_op 100.
- AUIPC 0010111 -> alu_op 101.
REQ-007 EXEC transitions SHALL be:
- R, I-ALU, LUI, AUIPC -> WB.
- LOAD, STORE -> MEM.
- BRANCH: branch 1 for one cycle, then -> FETCH.
- JAL, JALR: pc_write 1, then -> WB.
REQ-008 In MEM, mem_read (LOAD) or mem_write (STORE) SHALL be held until dmem_ready is 1; then LOAD -> WB and STORE -> FETCH.
REQ-009 In WB, reg_write SHALL be 1 for exactly one cycle; mem_to_reg SHALL be 01 for LOAD, 10 for JAL/JALR and 00 otherwise; the next state SHALL be FETCH.
REQ-010 A wait counter SHALL clear on entry to FETCH or MEM and increment each cycle its handshake ready is 0. When the count reaches TIMEOUT, the FSM SHALL pulse timeout_err for one cycle, go to FETCH without pc_write (the same PC is retried), and not increment instr_cnt.
REQ-011 A ready signal sampled in the same cycle the count reaches TIMEOUT SHALL win: the handshake completes and no timeout is reported.
REQ-012 instr_cnt SHALL increment by 1 on every completed instruction (WB exit, STORE MEM exit, BRANCH EXEC exit) and SHALL wrap modulo 2^CNT_W.
REQ-013 Latency SHALL be, with zero memory wait: R/I/LUI/AUIPC/JAL/JALR 4 cycles, LOAD 5, STORE 4, BRANCH 3.

Reset
REQ-014 While rst_n is 0, the state SHALL be FETCH, every output other than imem_req SHALL be 0, and instr_cnt and the wait counter SHALL be 0.
REQ-015 Reset asserted mid-instruction SHALL abort immediately with no reg_write or mem_write; imem_req SHALL assert in the first cycle after rst_n rises.

Configuration
REQ-016 With CTRL_TRAP_EN defined, an illegal opcode SHALL go from DECODE to TRAP, assert trap and hold it until reset. Without the macro, an illegal opcode SHALL be a NOP (DECODE -> FETCH, counted as retired) and trap SHALL be tied to 0.

Structure
REQ-017 A shared package SHALL hold the opcode constants, the alu_op encodings, the mem_to_reg encodings and the state enum.
REQ-018 The opcode-to-control decode SHALL be one combinational sub-module, control_decode; the FSM, wait counter and instr_cnt SHALL stay in the top level.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- After reset, opcode 0110011 with both readies held 1 -> reg_write pulses in cycle 4, mem_to_reg 00, alu_op 010, instr_cnt 1.
- opcode 0000011 with dmem_ready delayed 3 cycles -> mem_read high 4 cycles, then reg_write with mem_to_reg 01.
- imem_ready held 0 with TIMEOUT=16 -> timeout_err pulse in cycle 16, no pc_write, imem_req reasserted.
- opcode 1111111: with CTRL_TRAP_EN -> trap 1 and held; without it -> no strobes and instr_cnt increments.
- rst_n driven to 0 in MEM of a STORE -> mem_write drops at once, instr_cnt 0.
- CNT_W=4 with 16 branches (opcode 1100011) -> instr_cnt wraps to 0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared constants for the multicycle control unit: opcodes,
// alu_op and mem_to_reg encodings, and the FSM state enum.
package multicycle_control_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_BR    = 3'b001;
  localparam logic [2:0] ALU_R     = 3'b010;
  localparam logic [2:0] ALU_I     = 3'b011;
  localparam logic [2:0] ALU_LUI   = 3'b100;
  localparam logic [2:0] ALU_AUIPC = 3'b101;

  localparam logic [1:0] M2R_ALU = 2'b00;
  localparam logic [1:0] M2R_MEM = 2'b01;
  localparam logic [1:0] M2R_PC4 = 2'b10;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_TRAP
  } state_t;

endpackage

// File: rtl/control_decode.sv
// Combinational opcode decode: legality, instruction class flags,
// alu_op and alu_src. Ports: opcode_i in; legal/class/alu flags out.
module control_decode
  import multicycle_control_pkg::*;
#(
  parameter int ALU_OP_W = 3
) (
  input  logic [6:0]          opcode_i,
  output logic                legal_o,
  output logic                load_o,
  output logic                store_o,
  output logic                branch_o,
  output logic                jump_o,
  output logic                alu_src_o,
  output logic [ALU_OP_W-1:0] alu_op_o
);

  always_comb begin
    legal_o   = 1'b1;
    load_o    = 1'b0;
    store_o   = 1'b0;
    branch_o  = 1'b0;
    jump_o    = 1'b0;
    alu_src_o = 1'b0;
    alu_op_o  = ALU_OP_W'(ALU_ADD);
    unique case (1'b1)
      (opcode_i == OP_R):
        alu_op_o = ALU_OP_W'(ALU_R);
      (opcode_i == OP_I):
        alu_op_o = ALU_OP_W'(ALU_I);
      (opcode_i == OP_LOAD): begin
        load_o    = 1'b1;
        alu_src_o = 1'b1;
      end
      (opcode_i == OP_STORE): begin
        store_o   = 1'b1;
        alu_src_o = 1'b1;
      end
      (opcode_i == OP_BRANCH): begin
        branch_o = 1'b1;
        alu_op_o = ALU_OP_W'(ALU_BR);
      end
      (opcode_i == OP_JAL),
      (opcode_i == OP_JALR):
        jump_o = 1'b1;
      (opcode_i == OP_LUI):
        alu_op_o = ALU_OP_W'(ALU_LUI);
      (opcode_i == OP_AUIPC):
        alu_op_o = ALU_OP_W'(ALU_AUIPC);
      default:
        legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-V control FSM with memory-wait timeout and retired count.
// Ports: clk, rst_n, opcode, imem/dmem_ready in; strobes, alu_op,
// mem_to_reg, timeout_err, trap, instr_cnt out. Option: CTRL_TRAP_EN.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int TIMEOUT  = 16,
  parameter int CNT_W    = 32,
  parameter int ALU_OP_W = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [6:0]          opcode,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_write,
  output logic                alu_src,
  output logic                branch,
  output logic                mem_read,
  output logic                mem_write,
  output logic                reg_write,
  output logic [1:0]          mem_to_reg,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                timeout_err,
  output logic                trap,
  output logic [CNT_W-1:0]    instr_cnt
);

  localparam int WAIT_W = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic [6:0]          opcode_q;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [CNT_W-1:0]    cnt_q;
  logic                retire;
  logic                wait_hit;

  logic [6:0]          dec_op;
  logic                d_legal, d_load, d_store;
  logic                d_branch, d_jump, d_alu_src;
  logic [ALU_OP_W-1:0] d_alu_op;

  // DECODE sees the live IR field; later states use the latched copy.
  assign dec_op = (state_q == S_DECODE) ? opcode : opcode_q;

  control_decode #(
    .ALU_OP_W (ALU_OP_W)
  ) u_dec (
    .opcode_i  (dec_op),
    .legal_o   (d_legal),
    .load_o    (d_load),
    .store_o   (d_store),
    .branch_o  (d_branch),
    .jump_o    (d_jump),
    .alu_src_o (d_alu_src),
    .alu_op_o  (d_alu_op)
  );

  // Last wait cycle: a ready seen here still completes the handshake.
  assign wait_hit  = (wait_q == WAIT_W'(TIMEOUT - 1));
  assign instr_cnt = cnt_q;

  always_comb begin
    state_d     = state_q;
    retire      = 1'b0;
    imem_req    = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    alu_src     = 1'b0;
    branch      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    mem_to_reg  = M2R_ALU;
    alu_op      = '0;
    timeout_err = 1'b0;
    trap        = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        // Reset holds FETCH; keep the handshake strobes quiet then.
        if (rst_n) begin
          if (imem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end else if (wait_hit) begin
            timeout_err = 1'b1;
          end
        end
      end
      S_DECODE: begin
        if (d_legal) begin
          state_d = S_EXEC;
        end else begin
`ifdef CTRL_TRAP_EN
          state_d = S_TRAP;
`else
          state_d = S_FETCH;
          retire  = 1'b1;
`endif
        end
      end
      S_EXEC: begin
        alu_op  = d_alu_op;
        alu_src = d_alu_src;
        if (d_load || d_store) begin
          state_d = S_MEM;
        end else if (d_branch) begin
          branch  = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          pc_write = d_jump;
          state_d  = S_WB;
        end
      end
      S_MEM: begin
        alu_op    = d_alu_op;
        alu_src   = d_alu_src;
        mem_read  = d_load;
        mem_write = d_store;
        if (dmem_ready) begin
          state_d = d_load ? S_WB : S_FETCH;
          retire  = d_store;
        end else if (wait_hit) begin
          timeout_err = 1'b1;
          state_d     = S_FETCH;
        end
      end
      S_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = d_load ? M2R_MEM :
                     d_jump ? M2R_PC4 : M2R_ALU;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: begin
`ifdef CTRL_TRAP_EN
        trap = 1'b1;
`endif
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    wait_d = wait_q;
    if ((state_d != state_q) || timeout_err) begin
      wait_d = '0;
    end else if ((state_q == S_FETCH && !imem_ready) ||
                 (state_q == S_MEM && !dmem_ready)) begin
      wait_d = wait_q + WAIT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_FETCH;
      opcode_q <= '0;
      wait_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cnt_q   <= cnt_q + CNT_W'(retire);
      if (state_q == S_DECODE) begin
        opcode_q <= opcode;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control.
// Expected per-cycle outputs come from an instruction-level model.
module tb_multicycle_control;

  localparam int TMO = 16;

  localparam int K_ALU = 0;
  localparam int K_LD  = 1;
  localparam int K_ST  = 2;
  localparam int K_BR  = 3;
  localparam int K_JMP = 4;
  localparam int K_ILL = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = 7'h0;
  logic       imem_ready = 1'b0;
  logic       dmem_ready = 1'b0;
  logic       imem_req, ir_write, pc_write, alu_src, branch;
  logic       mem_read, mem_write, reg_write;
  logic [1:0] mem_to_reg;
  logic [2:0] alu_op;
  logic       timeout_err, trap;
  logic [3:0] instr_cnt;

  int checks = 0;
  int failures = 0;
  logic [3:0] cnt_m;

  multicycle_control #(
    .TIMEOUT  (TMO),
    .CNT_W    (4),
    .ALU_OP_W (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .opcode      (opcode),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .imem_req    (imem_req),
    .ir_write    (ir_write),
    .pc_write    (pc_write),
    .alu_src     (alu_src),
    .branch      (branch),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .mem_to_reg  (mem_to_reg),
    .alu_op      (alu_op),
    .timeout_err (timeout_err),
    .trap        (trap),
    .instr_cnt   (instr_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       ir_write;
    logic       pc_write;
    logic       alu_src;
    logic       branch;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] m2r;
    logic [2:0] aop;
    logic       terr;
    logic       trap;
    logic [3:0] cnt;
  } obs_t;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic obs_t sample();
    obs_t o;
    o.imem_req  = imem_req;
    o.ir_write  = ir_write;
    o.pc_write  = pc_write;
    o.alu_src   = alu_src;
    o.branch    = branch;
    o.mem_read  = mem_read;
    o.mem_write = mem_write;
    o.reg_write = reg_write;
    o.m2r       = mem_to_reg;
    o.aop       = alu_op;
    o.terr      = timeout_err;
    o.trap      = trap;
    o.cnt       = instr_cnt;
    return o;
  endfunction

  // Instruction-set table: class, alu_op, alu_src.
  task automatic spec_op(input logic [6:0] op, output int k,
                         output logic [2:0] aop, output logic asrc);
    asrc = 1'b0;
    aop  = 3'b000;
    case (op)
      7'b0110011: begin k = K_ALU; aop = 3'b010; end
      7'b0010011: begin k = K_ALU; aop = 3'b011; end
      7'b0110111: begin k = K_ALU; aop = 3'b100; end
      7'b0010111: begin k = K_ALU; aop = 3'b101; end
      7'b0000011: begin k = K_LD;  asrc = 1'b1; end
      7'b0100011: begin k = K_ST;  asrc = 1'b1; end
      7'b1100011: begin k = K_BR;  aop = 3'b001; end
      7'b1101111,
      7'b1100111: k = K_JMP;
      default:    k = K_ILL;
    endcase
  endtask

  // One clock: drive inputs at negedge, compare just after.
  task automatic cyc(string tag, logic [6:0] op, logic ir, logic dr,
                     obs_t e);
    @(negedge clk);
    opcode     = op;
    imem_ready = ir;
    dmem_ready = dr;
    #1;
    e.cnt = cnt_m;
    chk(tag, 32'(sample()), 32'(e));
  endtask

  task automatic do_reset();
    obs_t e;
    rst_n      = 1'b0;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    opcode     = 7'b0110011;
    repeat (2) @(negedge clk);
    #1;
    e = '0;
    e.imem_req = 1'b1;
    chk("reset", 32'(sample()), 32'(e));
    cnt_m = '0;
    @(posedge clk);
    #2 rst_n = 1'b1;
  endtask

  // fd/dd: ready-low cycles before the fetch/data handshake.
  task automatic run_instr(logic [6:0] op, int fd, int dd);
    obs_t e;
    int k;
    logic [2:0] aop;
    logic asrc;
    logic r;
    spec_op(op, k, aop, asrc);
    if (fd >= TMO) begin
      for (int i = 0; i < TMO; i++) begin
        e = '0;
        e.imem_req = 1'b1;
        e.terr = (i == TMO - 1);
        r = 1'($urandom);
        cyc("fetch_tmo", op, 1'b0, r, e);
      end
      return;
    end
    for (int i = 0; i < fd; i++) begin
      e = '0;
      e.imem_req = 1'b1;
      r = 1'($urandom);
      cyc("fetch_wait", op, 1'b0, r, e);
    end
    e = '0;
    e.imem_req = 1'b1;
    e.ir_write = 1'b1;
    e.pc_write = 1'b1;
    cyc("fetch", op, 1'b1, 1'($urandom), e);
    e = '0;
    cyc("decode", op, 1'($urandom), 1'($urandom), e);
    if (k == K_ILL) begin
`ifdef CTRL_TRAP_EN
      for (int i = 0; i < 5; i++) begin
        e = '0;
        e.trap = 1'b1;
        cyc("trap", op, 1'($urandom), 1'($urandom), e);
      end
`else
      cnt_m++;
`endif
      return;
    end
    e = '0;
    e.aop = aop;
    e.alu_src = asrc;
    e.branch = (k == K_BR);
    e.pc_write = (k == K_JMP);
    cyc("exec", op, 1'($urandom), 1'($urandom), e);
    if (k == K_BR) begin
      cnt_m++;
      return;
    end
    if (k == K_LD || k == K_ST) begin
      e = '0;
      e.aop = aop;
      e.alu_src = asrc;
      e.mem_read = (k == K_LD);
      e.mem_write = (k == K_ST);
      if (dd >= TMO) begin
        for (int i = 0; i < TMO; i++) begin
          e.terr = (i == TMO - 1);
          cyc("mem_tmo", op, 1'($urandom), 1'b0, e);
        end
        return;
      end
      for (int i = 0; i < dd; i++)
        cyc("mem_wait", op, 1'($urandom), 1'b0, e);
      cyc("mem", op, 1'($urandom), 1'b1, e);
      if (k == K_ST) begin
        cnt_m++;
        return;
      end
    end
    e = '0;
    e.reg_write = 1'b1;
    e.m2r = (k == K_LD) ? 2'b01 : (k == K_JMP) ? 2'b10 : 2'b00;
    cyc("wb", op, 1'($urandom), 1'($urandom), e);
    cnt_m++;
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 7) return int'($urandom_range(0, 3));
    if (r == 7) return TMO;
    return int'($urandom_range(4, TMO - 1));
  endfunction

  logic [6:0] ops [10];
  obs_t e;

  initial begin
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b1111111};

    do_reset();
    run_instr(7'b0110011, 0, 0);
    @(posedge clk);
    #1 chk("r_cnt", 32'(instr_cnt), 32'(cnt_m));

    run_instr(7'b0000011, 0, 3);
    run_instr(7'b0110011, TMO, 0);
    run_instr(7'b0110011, 0, 0);
    run_instr(7'b0000011, TMO - 1, TMO - 1);
    run_instr(7'b0100011, 0, TMO);
    run_instr(7'b1101111, 1, 0);
`ifndef CTRL_TRAP_EN
    run_instr(7'b1111111, 0, 0);
    @(posedge clk);
    #1 chk("nop_cnt", 32'(instr_cnt), 32'(cnt_m));
`endif

    // Reset in the middle of a STORE wait.
    run_instr(7'b0110011, 0, 0);
    cyc("st_fetch", 7'b0100011, 1'b1, 1'b0,
        '{imem_req:1, ir_write:1, pc_write:1, default:0});
    cyc("st_dec", 7'b0100011, 1'b0, 1'b0, '0);
    cyc("st_exec", 7'b0100011, 1'b0, 1'b0,
        '{alu_src:1, default:0});
    cyc("st_mem", 7'b0100011, 1'b0, 1'b0,
        '{alu_src:1, mem_write:1, default:0});
    #1 rst_n = 1'b0;
    #1;
    e = '0;
    e.imem_req = 1'b1;
    chk("st_abort", 32'(sample()), 32'(e));
    do_reset();

    for (int i = 0; i < 16; i++)
      run_instr(7'b1100011, 0, 0);
    @(posedge clk);
    #1 chk("wrap", 32'(instr_cnt), 32'(0));

    for (int n = 0; n < 200; n++) begin
      int idx;
`ifdef CTRL_TRAP_EN
      idx = int'($urandom_range(0, 8));
`else
      idx = int'($urandom_range(0, 9));
`endif
      run_instr(ops[idx], pick_delay(), pick_delay());
    end
    @(posedge clk);
    #1 chk("rand_cnt", 32'(instr_cnt), 32'(cnt_m));

`ifdef CTRL_TRAP_EN
    do_reset();
    run_instr(7'b1111111, 0, 0);
    do_reset();
    run_instr(7'b0110011, 0, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
